// File: rtl/rom_boot_loader_pkg.sv
// Shared types and constants for the ROM boot loader.
package rom_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_WIDTH      = 16;

endpackage

// File: rtl/rom_boot_loader_if.sv
// Host byte link plus ROM write port and core status of the boot loader.
interface rom_boot_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);

    logic                  boot_req;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rom_we;
    logic [ADDR_WIDTH-1:0] rom_waddr;
    logic [DATA_WIDTH-1:0] rom_wdata;
    logic                  hold;
    logic                  done;
    logic                  err;

    modport master (
        output boot_req, rx_data, rx_valid,
        input  rx_ready, rom_we, rom_waddr, rom_wdata, hold, done, err
    );

    modport slave (
        input  boot_req, rx_data, rx_valid,
        output rx_ready, rom_we, rom_waddr, rom_wdata, hold, done, err
    );

endinterface

// File: rtl/rom_boot_loader_word_packer.sv
// Packs accepted bytes LSB-first into 32-bit words and issues one ROM write
// strobe per completed word at sequential word addresses.
module rom_boot_word_packer
    import rom_boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  byte_en_i,
    input  logic [7:0]            byte_i,
    output logic                  last_lane_o,
    output logic                  rom_we_o,
    output logic [ADDR_WIDTH-1:0] rom_waddr_o,
    output logic [DATA_WIDTH-1:0] rom_wdata_o
);

    logic [1:0]            lane_q;
    logic [DATA_WIDTH-9:0] asm_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign last_lane_o = (lane_q == 2'(BYTES_PER_WORD - 1));
    assign rom_we_o    = we_q;
    assign rom_waddr_o = waddr_q;
    assign rom_wdata_o = wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q  <= '0;
            asm_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (clr_i) begin
                lane_q <= '0;
                idx_q  <= '0;
            end else if (byte_en_i) begin
                lane_q <= lane_q + 2'd1;
                // The top lane goes straight into the write register, so the
                // assembly register only ever holds the three lower lanes.
                if (last_lane_o) begin
                    we_q    <= 1'b1;
                    waddr_q <= idx_q;
                    wdata_q <= {byte_i, asm_q};
                    idx_q   <= idx_q + 1'b1;
                end else begin
                    case (lane_q)
                        2'd0:    asm_q[7:0]   <= byte_i;
                        2'd1:    asm_q[15:8]  <= byte_i;
                        default: asm_q[23:16] <= byte_i;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/rom_boot_loader.sv
// Framed byte-stream loader for the instruction ROM: LEN, payload, XOR checksum.
// Holds the core until the image is written and verified.
module rom_boot_loader
    import rom_boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    rom_boot_loader_if.slave bus
);

    localparam logic [LEN_WIDTH:0] DEPTH = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    state_e               state_q;
    logic                 rx_ready_q;
    logic                 hold_q;
    logic                 done_q;
    logic                 err_q;
    logic [7:0]           len_lo_q;
    logic [LEN_WIDTH-1:0] rem_q;
    logic [7:0]           chk_q;

    logic                 xfer;
    logic                 restart;
    logic                 last_lane;
    logic [LEN_WIDTH-1:0] len_d;

    assign xfer    = bus.rx_valid && rx_ready_q;
    assign restart = bus.boot_req &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign len_d   = {bus.rx_data, len_lo_q};

    assign bus.rx_ready = rx_ready_q;
    assign bus.hold     = hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    rom_boot_word_packer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk_i       (clk_100MHz),
        .rst_i       (rst),
        .clr_i       (restart),
        .byte_en_i   (xfer && (state_q == S_DATA)),
        .byte_i      (bus.rx_data),
        .last_lane_o (last_lane),
        .rom_we_o    (bus.rom_we),
        .rom_waddr_o (bus.rom_waddr),
        .rom_wdata_o (bus.rom_wdata)
    );

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            chk_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.boot_req) begin
                        state_q    <= S_LEN_LO;
                        rx_ready_q <= 1'b1;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        chk_q      <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo_q <= bus.rx_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        // Images larger than the ROM are rejected before any write.
                        if ({1'b0, len_d} > DEPTH) begin
                            state_q    <= S_ERROR;
                            rx_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA;
                            rem_q   <= len_d;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        chk_q <= chk_q ^ bus.rx_data;
                        if (last_lane) begin
                            rem_q <= rem_q - 1'b1;
                            if (rem_q == LEN_WIDTH'(1)) state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == chk_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
